// File: rtl/permutation_ctrl_pkg.sv
// Shared constants and types for the Ascon permutation sequencer.
package ascon_pack;

  typedef enum logic [1:0] {
    P12 = 2'b00,
    P8  = 2'b01,
    P6  = 2'b10
  } type_perm_mode;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ROUND,
    S_DONE
  } type_perm_state;

  localparam logic [3:0] START_P12  = 4'd0;
  localparam logic [3:0] START_P8   = 4'd4;
  localparam logic [3:0] START_P6   = 4'd6;
  localparam logic [3:0] ROUND_LAST = 4'd11;

  // Mode 11 has no enum member and falls through to the p12 start index.
  function automatic logic [3:0] start_index(input logic [1:0] mode);
    case (mode)
      P8:      start_index = START_P8;
      P6:      start_index = START_P6;
      default: start_index = START_P12;
    endcase
  endfunction

endpackage

// File: rtl/permutation_ctrl_if.sv
// Requester <-> permutation sequencer handshake. stall_i exists only with PERM_CTRL_STALL_EN.
interface permutation_ctrl_if;
  logic       start_i;
  logic [1:0] mode_i;
  logic       ack_i;
`ifdef PERM_CTRL_STALL_EN
  logic       stall_i;
`endif
  logic       ready_o;
  logic       sel_load_o;
  logic       en_reg_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

`ifdef PERM_CTRL_STALL_EN
  modport master (output start_i, mode_i, ack_i, stall_i,
                  input  ready_o, sel_load_o, en_reg_o, round_o, busy_o, done_o);
  modport slave  (input  start_i, mode_i, ack_i, stall_i,
                  output ready_o, sel_load_o, en_reg_o, round_o, busy_o, done_o);
`else
  modport master (output start_i, mode_i, ack_i,
                  input  ready_o, sel_load_o, en_reg_o, round_o, busy_o, done_o);
  modport slave  (input  start_i, mode_i, ack_i,
                  output ready_o, sel_load_o, en_reg_o, round_o, busy_o, done_o);
`endif
endinterface

// File: rtl/permutation_ctrl_round_counter.sv
// 4-bit round-constant index: load start index on accept, step once per enabled round.
module round_counter (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] count
);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)   count <= 4'd0;
    else if (load) count <= load_val;
    else if (inc)  count <= count + 4'd1;
  end

endmodule

// File: rtl/permutation_ctrl.sv
// Ascon permutation sequencer: IDLE -> LOAD -> ROUND x N -> DONE, N = 12/8/6.
// Optional stall input enabled by defining PERM_CTRL_STALL_EN.
module permutation_ctrl
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               reset_i,
  permutation_ctrl_if.slave  bus
);

  type_perm_state state_q, state_d;
  logic [3:0]     count;
  logic           ctr_load, ctr_inc, advance;

  // A stall only gates LOAD/ROUND; it must drop en_reg_o in the same cycle,
  // so it is the one input with a combinational path to an output.
`ifdef PERM_CTRL_STALL_EN
  assign advance = ~bus.stall_i;
`else
  assign advance = 1'b1;
`endif

  round_counter u_round_counter (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .load     (ctr_load),
    .load_val (start_index(bus.mode_i)),
    .inc      (ctr_inc),
    .count    (count)
  );

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ctr_load = 1'b0;
    ctr_inc  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start_i) begin
        state_d  = S_LOAD;
        ctr_load = 1'b1;
      end
      S_LOAD: if (advance) state_d = S_ROUND;
      // Leaving at ROUND_LAST without incrementing keeps the index in 0..11.
      S_ROUND: if (advance) begin
        if (count == ROUND_LAST) state_d = S_DONE;
        else                     ctr_inc = 1'b1;
      end
      S_DONE: if (bus.ack_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready_o    = (state_q == S_IDLE);
  assign bus.busy_o     = (state_q == S_LOAD) || (state_q == S_ROUND);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.sel_load_o = (state_q == S_LOAD);
  assign bus.en_reg_o   = bus.busy_o && advance;
  assign bus.round_o    = count;

endmodule

// File: tb/tb_permutation_ctrl.sv
// Scoreboard bench for permutation_ctrl: driver pushes expected register-enable events, monitor pops.
module tb_permutation_ctrl;
  import ascon_pack::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  permutation_ctrl_if pif();
  permutation_ctrl dut (.clock_i(clk), .reset_i(rst), .bus(pif));

  typedef struct {
    logic       sel;
    logic [3:0] rnd;
    logic       done;
  } ev_t;

  ev_t sb[$];
  int  n_chk  = 0;
  int  n_pass = 0;
  int  cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int nrounds(input logic [1:0] m);
    return (m == 2'b01) ? 8 : (m == 2'b10) ? 6 : 12;
  endfunction

  // Reference: one load beat at the first index, then one beat per round index up to 11, then done.
  task automatic push_model(input logic [1:0] m);
    int first = 12 - nrounds(m);
    sb.push_back('{sel: 1'b1, rnd: 4'(first), done: 1'b0});
    for (int r = first; r < 12; r++) sb.push_back('{sel: 1'b0, rnd: 4'(r), done: 1'b0});
    sb.push_back('{sel: 1'b0, rnd: 4'd0, done: 1'b1});
  endtask

  // Monitor samples mid-cycle; inputs change just after the rising edge.
  logic prev_done = 1'b0;
  ev_t  mev;
  always @(negedge clk) begin
    if (rst) prev_done <= 1'b0;
    else begin
      if (pif.en_reg_o) begin
        if (sb.size() == 0) chk("unexpected_enable", 1, 0);
        else begin
          mev = sb.pop_front();
          chk("beat_is_round", int'(mev.done), 0);
          chk("sel_load", int'(pif.sel_load_o), int'(mev.sel));
          chk("round_idx", int'(pif.round_o), int'(mev.rnd));
          chk("busy_when_en", int'(pif.busy_o), 1);
        end
      end
      if (pif.done_o && !prev_done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          mev = sb.pop_front();
          chk("done_event", int'(mev.done), 1);
        end
      end
      prev_done <= pif.done_o;
    end
  end

  task automatic drive_idle();
    pif.start_i = 1'b0;
    pif.ack_i   = 1'b0;
`ifdef PERM_CTRL_STALL_EN
    pif.stall_i = 1'b0;
`endif
  endtask

  task automatic run_perm(input logic [1:0] m, input bit noise, input int stall_at, input int stall_len);
    int  n = nrounds(m);
    int  a, stalls = 0, waited = 0, stall_left = 0, hold;
    bit  seen = 1'b0, stall_used = 1'b0;
    @(posedge clk); #1;
    chk("ready_before_start", int'(pif.ready_o), 1);
    push_model(m);
    pif.start_i = 1'b1;
    pif.mode_i  = m;
    pif.ack_i   = noise ? 1'($urandom % 2) : 1'b0;
    @(posedge clk); #1;
    a = cyc;
    chk("load_state", int'({pif.busy_o, pif.ready_o, pif.sel_load_o}), 3'b101);
    while (!seen && waited < 80) begin
      if (pif.done_o) seen = 1'b1;
      else begin
        pif.start_i = noise ? 1'($urandom % 2) : 1'b0;
        pif.ack_i   = noise ? 1'($urandom % 2) : 1'b0;
        if (noise) pif.mode_i = 2'($urandom);
`ifdef PERM_CTRL_STALL_EN
        pif.stall_i = 1'b0;
        if (stall_at >= 0 && !stall_used && int'(pif.round_o) == stall_at && !pif.sel_load_o) begin
          stall_used = 1'b1;
          stall_left = stall_len;
        end
        if (stall_left > 0) begin
          pif.stall_i = 1'b1;
          stall_left--;
          #1;
          chk("stall_en_low", int'(pif.en_reg_o), 0);
          chk("stall_round_hold", int'(pif.round_o), stall_at);
        end else if (noise && ($urandom % 4 == 0)) pif.stall_i = 1'b1;
        if (pif.stall_i) stalls++;
`endif
        waited++;
        @(posedge clk); #1;
      end
    end
    drive_idle();
    if (!seen) begin
      chk("done_timeout", 0, 1);
      sb.delete();
      return;
    end
    chk("latency", cyc - a, n + 1 + stalls);
    hold = $urandom % 3;
    repeat (hold) begin
      pif.start_i = noise ? 1'($urandom % 2) : 1'b0;
      chk("done_held", int'({pif.done_o, pif.en_reg_o, pif.busy_o}), 3'b100);
      @(posedge clk); #1;
    end
    pif.ack_i   = 1'b1;
    pif.start_i = noise;
    @(posedge clk); #1;
    drive_idle();
    chk("after_ack", int'({pif.ready_o, pif.done_o}), 2'b10);
    @(posedge clk); #1;
    chk("no_queued_start", int'({pif.ready_o, pif.busy_o}), 2'b10);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  function automatic int out_vec();
    return int'({pif.ready_o, pif.busy_o, pif.done_o, pif.en_reg_o, pif.sel_load_o, pif.round_o});
  endfunction

  localparam int RESET_VEC = 9'b1_0000_0000;

  initial begin
    int w;
    rst = 1'b1;
    pif.mode_i = 2'b00;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", out_vec(), RESET_VEC);
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      chk("idle_hold", out_vec(), RESET_VEC);
    end

    run_perm(2'b00, 1'b0, -1, 0);
    run_perm(2'b01, 1'b0, -1, 0);
    run_perm(2'b10, 1'b0, -1, 0);
    run_perm(2'b11, 1'b0, -1, 0);
    for (int i = 0; i < 8; i++) run_perm(2'($urandom), 1'b1, -1, 0);

    // Reset while rounds are in flight, then a normal p8 run.
    @(posedge clk); #1;
    push_model(2'b00);
    pif.start_i = 1'b1;
    pif.mode_i  = 2'b00;
    @(posedge clk); #1;
    pif.start_i = 1'b0;
    w = 0;
    while (!(pif.round_o == 4'd5 && pif.busy_o && !pif.sel_load_o) && w < 30) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_round5", int'(w < 30), 1);
    #2 rst = 1'b1;
    #1 chk("async_reset_outputs", out_vec(), RESET_VEC);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_perm(2'b01, 1'b0, -1, 0);

`ifdef PERM_CTRL_STALL_EN
    run_perm(2'b00, 1'b0, 7, 3);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
